// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_pkg : shared types and constants for the oversampling UART receiver
// Revision    : 1.0
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_if : received-frame output bundle (payload plus result pulses)
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  framing_error;

  modport master (
    output P_DATA,
    output data_valid,
    output parity_error,
    output framing_error
  );

  modport slave (
    input P_DATA,
    input data_valid,
    input parity_error,
    input framing_error
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_sampler : per-bit edge counter and 3-tap majority vote
// Revision        : 1.0
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  wire logic                      i_clk,
  input  wire logic                      i_rst_n,
  input  wire logic                      i_rx,
  input  wire logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  wire logic                      i_run,
  output logic                           o_sample_bit,
  output logic                           o_sample_done,
  output logic                           o_bit_end
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [1:0]                tap_q, tap_d;
  logic                      sample_q, sample_d;

  logic [PRESCALE_WIDTH-1:0] w_sample_pt;
  logic [PRESCALE_WIDTH-1:0] w_last;
  logic                      w_vote;

  // tap_q[1]/tap_q[0] hold RX_IN from two/one cycles ago, so at the sample
  // point they line up with Prescale/2-1 and Prescale/2.
  always_comb begin
    w_sample_pt   = (i_prescale >> 1) + ONE;
    w_last        = i_prescale - ONE;
    w_vote        = majority3(tap_q[1], tap_q[0], i_rx);
    o_sample_done = (edge_cnt_q == w_sample_pt);
    o_bit_end     = (edge_cnt_q == w_last);
    o_sample_bit  = o_sample_done ? w_vote : sample_q;
    sample_d      = o_sample_bit;
    tap_d         = {tap_q[0], i_rx};
  end

  // Kept apart from the output logic: i_run is derived from the FSM's next
  // state, which itself depends on the outputs above.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (!i_run) begin
      edge_cnt_d = '0;
    end else if (o_bit_end) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_cnt_q <= '0;
      tap_q      <= 2'b11;
      sample_q   <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      tap_q      <= tap_d;
      sample_q   <= sample_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx  : oversampling UART receiver delivering only clean frames
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  wire logic                      CLK,
  input  wire logic                      RST,
  input  wire logic                      RX_IN,
  input  wire logic [PRESCALE_WIDTH-1:0] Prescale,
  input  wire logic                      PAR_EN,
  input  wire logic                      PAR_TYP,
  uart_rx_if.master                      bus
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

  state_e                    state_q, state_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_err_q, par_err_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      parity_error_q, parity_error_d;
  logic                      framing_error_q, framing_error_d;

  logic                      w_sample_bit;
  logic                      w_sample_done;
  logic                      w_bit_end;
  logic                      w_run;
  logic                      w_par_exp;
  logic [PRESCALE_WIDTH-1:0] w_prescale;

  // The live Prescale input only matters on the start-detect cycle.
  assign w_prescale = (state_q == S_IDLE) ? Prescale : prescale_q;
  assign w_run      = (state_d != S_IDLE);
  assign w_par_exp  = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .i_clk         (CLK),
    .i_rst_n       (RST),
    .i_rx          (RX_IN),
    .i_prescale    (w_prescale),
    .i_run         (w_run),
    .o_sample_bit  (w_sample_bit),
    .o_sample_done (w_sample_done),
    .o_bit_end     (w_bit_end)
  );

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_err_d       = par_err_q;
    prescale_d      = prescale_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    p_data_d        = p_data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d    = S_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (w_sample_done && w_sample_bit) begin
          state_d = S_IDLE;
        end else if (w_bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample_done) begin
          shift_d = {w_sample_bit, shift_q[DATA_WIDTH-1:1]};
        end
        if (w_bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (w_sample_done) begin
          par_err_d = par_err_q | (w_sample_bit != w_par_exp);
        end
        if (w_bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // A bad stop bit outranks a parity mismatch; only one flag fires.
        if (w_bit_end) begin
          state_d = S_IDLE;
          if (!w_sample_bit) begin
            framing_error_d = 1'b1;
          end else if (par_err_q) begin
            parity_error_d = 1'b1;
          end else begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      prescale_q      <= '0;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      p_data_q        <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_err_q       <= par_err_d;
      prescale_q      <= prescale_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      p_data_q        <= p_data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign bus.P_DATA        = p_data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : directed frames with a queue-based scoreboard on frame results
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  localparam int K_VALID   = 0;
  localparam int K_PARITY  = 1;
  localparam int K_FRAMING = 2;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  uart_rx_if #(.DATA_WIDTH(DW)) rx_bus ();

  uart_rx #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .RX_IN    (rx),
    .Prescale (prescale),
    .PAR_EN   (par_en),
    .PAR_TYP  (par_typ),
    .bus      (rx_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame bit by bit and queues the result the receiver owes us.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit pbit,
                            input bit stop, input bit toggle, input int kind,
                            input logic [7:0] exp_data);
    exp_t e;
    e.kind = kind;
    e.data = exp_data;
    e.cyc  = cyc + (10 + (pen ? 1 : 0)) * p;
    exp_q.push_back(e);
    rx = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      if (toggle && i == 3) prescale = 6'd16;
      if (toggle && i == 6) prescale = 6'd8;
      rx = d[i];
      tick(p);
    end
    if (pen) begin
      rx = pbit;
      tick(p);
    end
    rx = stop;
    tick(p);
  endtask

  always @(negedge clk) begin : monitor
    int   nflags;
    int   kind_act;
    exp_t e;
    nflags = int'(rx_bus.data_valid) + int'(rx_bus.parity_error) + int'(rx_bus.framing_error);
    if (nflags != 0) begin
      check("flag_count", nflags, 1);
      kind_act = rx_bus.data_valid ? K_VALID : (rx_bus.parity_error ? K_PARITY : K_FRAMING);
      if (exp_q.size() == 0) begin
        check("unexpected_event_count", nflags, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind_act, e.kind);
        check("p_data", int'(rx_bus.P_DATA), int'(e.data));
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = PAR_EVEN;
    tick(3);
    check("reset_p_data", int'(rx_bus.P_DATA), 0);
    check("reset_data_valid", int'(rx_bus.data_valid), 0);
    check("reset_parity_error", int'(rx_bus.parity_error), 0);
    check("reset_framing_error", int'(rx_bus.framing_error), 0);
    rst_n = 1'b1;
    tick(5);

    // 0xA5 has four ones: even parity bit 0 is correct.
    prescale = 6'(PRESCALE_X8);
    par_en   = 1'b1;
    par_typ  = PAR_EVEN;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, K_VALID, 8'hA5);
    tick(10);

    // 0x3C has four ones: odd parity needs 1, we send 0.
    prescale = 6'(PRESCALE_X16);
    par_typ  = PAR_ODD;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, K_PARITY, 8'hA5);
    tick(10);

    prescale = 6'(PRESCALE_X32);
    par_en   = 1'b0;
    send_frame(8'hBB, 32, 1'b0, 1'b0, 1'b0, 1'b0, K_FRAMING, 8'hA5);
    rx = 1'b1;
    tick(40);
    send_frame(8'hCC, 32, 1'b0, 1'b0, 1'b1, 1'b0, K_VALID, 8'hCC);
    tick(10);

    // Start glitch: three low cycles, receiver must be idle again by cycle 6.
    prescale = 6'(PRESCALE_X8);
    t0 = cyc;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3);
    check("glitch_idle_cycle", cyc - t0, 6);
    check("glitch_state_idle", int'(dut.state_q == S_IDLE), 1);
    tick(10);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b0, K_VALID, 8'hAA);
    tick(10);

    // Back-to-back frames; Prescale wiggles mid-frame 2.
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, 1'b0, K_VALID, 8'hAA);
    send_frame(8'h05, 8, 1'b0, 1'b0, 1'b1, 1'b1, K_VALID, 8'h05);
    send_frame(8'h10, 8, 1'b0, 1'b0, 1'b1, 1'b0, K_VALID, 8'h10);
    tick(10);

    // Reset in the middle of the data bits of 0xDD.
    rx = 1'b0; tick(8);
    rx = 1'b1; tick(8);
    rx = 1'b0; tick(8);
    rx = 1'b1; tick(4);
    rst_n = 1'b0;
    #1;
    check("midreset_p_data", int'(rx_bus.P_DATA), 0);
    check("midreset_data_valid", int'(rx_bus.data_valid), 0);
    check("midreset_parity_error", int'(rx_bus.parity_error), 0);
    check("midreset_framing_error", int'(rx_bus.framing_error), 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, K_VALID, 8'h11);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("pending_expected_events", exp_q.size(), 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that deserializes the serial line into byte frames for the system controller. It sits directly upstream of the controller's receive path: its `P_DATA` / `data_valid` pair, after the RX-to-system data synchronizer, becomes the controller's `RX_P_DATA` / `RX_P_VLD` command and operand stream. It checks start-glitch, parity and stop-bit errors, and delivers only clean frames.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame
- `PRESCALE_WIDTH`, 6, width of the oversampling-ratio input
- `CLK` input 1: receive oversampling clock; all logic on its rising edge
- `RST` input 1: asynchronous, active-low reset
- `RX_IN` input 1: serial line, idle high; synchronous to `CLK` (synchronized externally)
- `Prescale` input `PRESCALE_WIDTH`: oversampling ratio, legal values 8, 16, 32
- `PAR_EN` input 1: 1 = parity bit present
- `PAR_TYP` input 1: 0 = even, 1 = odd
- `P_DATA` output `DATA_WIDTH`: last clean frame payload, LSB received first
- `data_valid` output 1: one-cycle pulse, clean frame on `P_DATA`
- `parity_error` output 1: one-cycle pulse, frame dropped for bad parity
- `framing_error` output 1: one-cycle pulse, frame dropped for stop bit sampled 0

## Operation
- Reset values: FSM in IDLE, all counters 0, `P_DATA` = 0, and all three flags 0. A reset mid-frame aborts the frame with no flag.
- States: IDLE, START, DATA, PARITY, STOP.
- Each bit lasts `Prescale` cycles, counted by `edge_cnt` 0..`Prescale`-1. `bit_cnt` counts DATA bits 0..`DATA_WIDTH`-1.
- Bit value is the 2-of-3 majority of `RX_IN` at `edge_cnt` = `Prescale`/2-1, `Prescale`/2 and `Prescale`/2+1. It is registered at `Prescale`/2+1.
- IDLE → START:
  - Taken when `RX_IN` = 0. That cycle is `edge_cnt` 0 of the start bit.
  - `Prescale`, `PAR_EN` and `PAR_TYP` are latched at this transition. Changes to them mid-frame are ignored.
- START:
  - If the sampled bit is 1, it is a glitch. Return to IDLE after `edge_cnt` = `Prescale`/2+1 with no flag.
  - Otherwise go to DATA at `edge_cnt` wrap.
- DATA:
  - Shift sampled bits into a shift register, LSB first.
  - After bit `DATA_WIDTH`-1 wraps, go to PARITY if `PAR_EN`, else STOP.
- PARITY:
  - Compare the sampled bit with the XOR of the payload bits, inverted when `PAR_TYP` = 1.
  - Store a mismatch in a sticky error bit for this frame.
- STOP: at `edge_cnt` wrap, resolve the frame in priority order:
  - stop sample = 0 → `framing_error` pulse (this also covers a parity mismatch);
  - else parity mismatch → `parity_error` pulse;
  - else → `P_DATA` ← shift register and `data_valid` pulse.
- After STOP, always go to IDLE. IDLE checks `RX_IN` in the same cycle, so a back-to-back start bit immediately following the stop bit is not lost.
- `P_DATA` holds its value through errored frames and idle time.
- At most one flag is asserted in any cycle.
- `Prescale` values other than 8/16/32 have unspecified behaviour but must not lock up the FSM: any wrap returns to IDLE.

## Timing
- Frame length N = (1 + `DATA_WIDTH` + `PAR_EN` + 1) × `Prescale` cycles, with cycle 0 being the first low `RX_IN` cycle.
- Flags and `P_DATA` update are registered and visible at cycle N.
- The next frame's start bit may fall at cycle N. If so, FSM enters START at cycle N+1 with `edge_cnt` = 1.
- A glitch is rejected by cycle `Prescale`/2+2. After that, IDLE re-arms.
- Throughput: one byte per N cycles, continuous.

## Structure
- Package `uart_rx_pkg`:
  - state enum (5 states);
  - legal prescale constants 8/16/32;
  - parity-type constants EVEN = 0, ODD = 1.
- Sub-module `uart_rx_sampler`:
  - owns `edge_cnt` and the 3-tap majority vote;
  - outputs `sample_bit`, `sample_done` and `bit_end` (`edge_cnt` = `Prescale`-1) to the FSM.
- The top level owns the FSM, `bit_cnt`, shift register, parity check and output registers.

## Test plan
- `Prescale` = 8, `PAR_EN` = 1, even parity, byte 0xA5 with parity bit 0 → `data_valid` at cycle 88, `P_DATA` = 0xA5, no error flags.
- `Prescale` = 16, `PAR_EN` = 1, odd parity, byte 0x3C sent with parity bit 0 (correct odd parity is 1) → `parity_error` pulse at cycle 176, `data_valid` stays 0, `P_DATA` unchanged from the previous frame.
- `Prescale` = 32, `PAR_EN` = 0, byte 0xBB with stop bit forced 0 → `framing_error` at cycle 320, then the line returns high and a following 0xCC frame is received cleanly.
- Start glitch: `RX_IN` low for 3 cycles at `Prescale` = 8 → no flags, FSM back in IDLE by cycle 6, then a valid 0xAA frame is received.
- Back-to-back frames 0xAA, 0x05, 0x10 at `Prescale` = 8, `PAR_EN` = 0:
  - three `data_valid` pulses spaced exactly 80 cycles apart, in order;
  - `Prescale` toggled to 16 during frame 2 has no effect.
- `RST` asserted mid-DATA of frame 0xDD → all outputs 0 immediately, no flag; the next full frame 0x11 is received correctly.
